// File: rtl/comm_sender_mb.sv
// Host-side command sender: shifts a multi-byte command out over 8N1 UART,
// then gathers a multi-byte response on the receive line with a timeout.
module comm_sender_mb #(
  parameter int BAUD_DIV    = 2604,
  parameter int CMD_BYTES   = 2,
  parameter int RSP_BYTES   = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [8*CMD_BYTES-1:0]                  cmd,
  input  logic                                    snd_cmd,
  input  logic                                    clr_resp_rdy,
  input  logic                                    RX,
  output logic                                    TX,
  output logic                                    busy,
  output logic                                    cmd_snt,
  output logic                                    resp_rdy,
  output logic [(RSP_BYTES>0 ? 8*RSP_BYTES : 1)-1:0] resp,
  output logic                                    timeout
);

  localparam int CW = 8*CMD_BYTES;
  localparam int RW = (RSP_BYTES > 0) ? 8*RSP_BYTES : 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(TIMEOUT_CYC+1);

  localparam logic [BW-1:0] B_END  = BW'(BAUD_DIV-1);
  localparam logic [BW-1:0] B_HALF = BW'(BAUD_DIV/2-1);
  localparam logic [TW-1:0] T_END  = TW'(TIMEOUT_CYC);
  localparam logic [3:0]    R_LAST = 4'(RSP_BYTES-1);

  typedef enum logic [1:0] {
    IDLE,
    TX_BYTE,
    RSP_WAIT
  } state_t;

  typedef enum logic [1:0] {
    R_HUNT,
    R_START,
    R_DATA,
    R_STOP
  } rx_t;

  state_t state, state_nxt;
  rx_t    rx_state, rx_nxt;

  logic [CW-1:0] sh_buf;
  logic [3:0]    byte_idx;
  logic [3:0]    bit_idx;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] rx_cnt;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_nxt;
  logic [3:0]    rsp_cnt;
  logic [RW-1:0] acc;
  logic [RW-1:0] acc_nxt;
  logic [7:0]    rx_sh;
  logic [7:0]    cur_byte;
  logic [2:0]    rx_bit;
  logic          rx_s1, rx_s2, rx_d;
  logic          tx;
  logic          start;
  logic          tx_tick, tx_end;
  logic          rx_half, rx_full, rx_fall;
  logic          rx_ok, rsp_done, to_hit;

  assign TX       = tx;
  assign busy     = (state != IDLE);
  assign cur_byte = sh_buf[CW-1 -: 8];
  assign acc_nxt  = (acc << 8) | RW'(rx_sh);

  always_comb begin
    state_nxt = state;
    rx_nxt    = rx_state;
    start     = (state == IDLE) && snd_cmd;
    tx_tick   = (state == TX_BYTE) && (baud_cnt == B_END);
    tx_end    = tx_tick && (bit_idx == 4'd9) && (byte_idx == 4'd0);
    rx_half   = (rx_cnt == B_HALF);
    rx_full   = (rx_cnt == B_END);
    rx_fall   = rx_d && !rx_s2;
    rx_ok     = (state == RSP_WAIT) && (rx_state == R_STOP)
                && rx_full && rx_s2;
    rsp_done  = rx_ok && (rsp_cnt == R_LAST);
    to_nxt    = (to_cnt == T_END) ? to_cnt : to_cnt + 1'b1;
    to_hit    = (state == RSP_WAIT) && (to_nxt == T_END);

    unique case (state)
      IDLE:     if (snd_cmd) state_nxt = TX_BYTE;
      TX_BYTE:  if (tx_end)
                  state_nxt = (RSP_BYTES == 0) ? IDLE : RSP_WAIT;
      RSP_WAIT: if (rsp_done || to_hit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    if (state != RSP_WAIT) begin
      rx_nxt = R_HUNT;
    end else begin
      unique case (rx_state)
        R_HUNT:  if (rx_fall) rx_nxt = R_START;
        R_START: if (rx_half) rx_nxt = rx_s2 ? R_HUNT : R_DATA;
        R_DATA:  if (rx_full && rx_bit == 3'd7) rx_nxt = R_STOP;
        R_STOP:  if (rx_full) rx_nxt = R_HUNT;
        default: rx_nxt = R_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rx_state <= R_HUNT;
    end else begin
      state    <= state_nxt;
      rx_state <= rx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx       <= 1'b1;
      cmd_snt  <= 1'b0;
      resp_rdy <= 1'b0;
      timeout  <= 1'b0;
      resp     <= '0;
      sh_buf   <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      to_cnt   <= '0;
      rsp_cnt  <= '0;
      acc      <= '0;
    end else begin
      if (start) begin
        sh_buf   <= cmd;
        byte_idx <= 4'(CMD_BYTES-1);
        bit_idx  <= '0;
        baud_cnt <= '0;
        tx       <= 1'b0;
        cmd_snt  <= 1'b0;
        timeout  <= 1'b0;
      end

      if (state == TX_BYTE) begin
        if (!tx_tick) begin
          baud_cnt <= baud_cnt + 1'b1;
        end else begin
          baud_cnt <= '0;
          if (bit_idx != 4'd9) begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= (bit_idx == 4'd8) || cur_byte[bit_idx[2:0]];
          end else if (byte_idx != 4'd0) begin
            byte_idx <= byte_idx - 1'b1;
            bit_idx  <= '0;
            sh_buf   <= sh_buf << 8;
            tx       <= 1'b0;
          end else begin
            tx      <= 1'b1;
            cmd_snt <= 1'b1;
            to_cnt  <= '0;
            rsp_cnt <= '0;
            acc     <= '0;
          end
        end
      end

      if (state == RSP_WAIT) begin
        to_cnt <= to_nxt;
        if (rx_ok && rsp_cnt != 4'd8) begin
          acc     <= acc_nxt;
          rsp_cnt <= rsp_cnt + 1'b1;
        end
        // a completed response beats a same-cycle timeout
        if (rsp_done) resp <= acc_nxt;
        else if (to_hit) timeout <= 1'b1;
      end

      if (rsp_done) resp_rdy <= 1'b1;
      else if (clr_resp_rdy || start) resp_rdy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_d   <= 1'b1;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      if (rx_state == R_HUNT || (rx_state == R_START && rx_half)
          || rx_full)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == R_START) begin
        rx_bit <= '0;
      end else if (rx_state == R_DATA && rx_full) begin
        rx_sh <= {rx_s2, rx_sh[7:1]};
        if (rx_bit != 3'd7) rx_bit <= rx_bit + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comm_sender_mb.sv
// Scoreboard bench for comm_sender_mb: TX decoder and outcome monitor
// pop expectations queued by the stimulus; a loopback model replies on RX.
module tb_comm_sender_mb;

  localparam int B     = 16;
  localparam int NC    = 4;
  localparam int NR    = 2;
  localparam int TO    = 500;
  localparam int FRAME = 10*B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd = '0;
  logic        snd_cmd = 1'b0;
  logic        clr_resp_rdy = 1'b0;
  logic        RX = 1'b1;
  logic        TX, busy, cmd_snt, resp_rdy, timeout;
  logic [15:0] resp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         send;
    bit         glitch;
    int         dly;
    logic [7:0] d0;
    logic [7:0] d1;
  } rep_t;

  typedef struct {
    bit          to;
    logic [15:0] r;
  } out_t;

  logic [7:0]  exp_tx[$];
  rep_t        rep_q[$];
  out_t        exp_out[$];
  logic [15:0] last_resp = '0;

  comm_sender_mb #(
    .BAUD_DIV(B), .CMD_BYTES(NC), .RSP_BYTES(NR), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd),
    .clr_resp_rdy(clr_resp_rdy), .RX(RX), .TX(TX), .busy(busy),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // TX line decoder
  logic       ptx = 1'b1;
  bit         tx_act = 0;
  int         ph, k;
  logic [9:0] fr;
  logic [7:0] e;

  always @(negedge clk) begin
    if (rst) begin
      tx_act = 0;
    end else if (tx_act) begin
      ph++;
      if (ph >= B/2 && (ph - B/2) % B == 0) begin
        k = (ph - B/2) / B;
        fr[k] = TX;
        if (k == 9) begin
          tx_act = 0;
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_extra actual=%h required=none", fr[8:1]);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", fr[8:1], e);
            chk("tx_frame", {fr[9], fr[0]}, 2'b10);
          end
        end
      end
    end else if (ptx && !TX) begin
      tx_act = 1;
      ph = 0;
    end
    ptx = TX;
  end

  // outcome monitor
  logic prr = 1'b0, pto = 1'b0;
  out_t o;

  always @(negedge clk) begin
    if (!rst && ((resp_rdy && !prr) || (timeout && !pto))) begin
      if (exp_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_extra actual=%h required=none", resp);
      end else begin
        o = exp_out.pop_front();
        chk("out_timeout", timeout, o.to);
        chk("out_resp_rdy", resp_rdy, !o.to);
        chk("out_resp", resp, o.r);
        chk("out_busy", busy, 0);
      end
    end
    prr = resp_rdy;
    pto = timeout;
  end

  task automatic uart_tx(input logic [7:0] d);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (B) @(posedge clk);
    end
  endtask

  // loopback responder
  initial begin
    rep_t r;
    logic sq;
    sq = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && cmd_snt && !sq && rep_q.size() > 0) begin
        r = rep_q.pop_front();
        if (r.send) begin
          repeat (r.dly) @(posedge clk);
          if (r.glitch) begin
            RX = 1'b0;
            repeat (3) @(posedge clk);
            RX = 1'b1;
            repeat (2*B) @(posedge clk);
          end
          uart_tx(r.d0);
          repeat (r.dly % 4) @(posedge clk);
          uart_tx(r.d1);
        end
      end
      sq = cmd_snt;
    end
  end

  task automatic run_txn(input logic [31:0] c, input bit send,
                         input bit glitch, input bit repulse,
                         input bit hold_clr, input logic [7:0] d0,
                         input logic [7:0] d1, input int dly);
    int   n;
    rep_t r;
    out_t x;
    for (int i = NC-1; i >= 0; i--) exp_tx.push_back(c[8*i +: 8]);
    r.send = send; r.glitch = glitch; r.dly = dly;
    r.d0 = d0; r.d1 = d1;
    rep_q.push_back(r);
    if (send) begin
      x.to = 0; x.r = {d0, d1}; last_resp = x.r;
    end else begin
      x.to = 1; x.r = last_resp;
    end
    exp_out.push_back(x);

    @(posedge clk); #1;
    cmd = c; snd_cmd = 1'b1; clr_resp_rdy = hold_clr;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    chk("busy_start", busy, 1);
    n = 0;
    while (!cmd_snt && n < 4*NC*FRAME) begin
      if (repulse && n == FRAME + 5) begin
        cmd = '1; snd_cmd = 1'b1;
      end else begin
        snd_cmd = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    snd_cmd = 1'b0;
    chk("cmd_snt_time", n, NC*FRAME);
    if (!send) begin
      n = 0;
      while (!timeout && n < 2*TO) begin
        @(posedge clk); #1;
        n++;
      end
      chk("timeout_time", n, TO);
    end
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_fall", busy, 0);
    if (hold_clr && send) begin
      chk("set_wins", resp_rdy, 1);
      @(posedge clk); #1;
      chk("clr_next", resp_rdy, 0);
    end
    clr_resp_rdy = 1'b0;
    repeat ($urandom_range(1, 5)) @(posedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", TX, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_snt", cmd_snt, 0);
    chk("rst_resp_rdy", resp_rdy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_resp", resp, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_txn(32'h01234567, 1, 0, 0, 0, 8'hBE, 8'hEF, 10);
    run_txn(32'hDEADBEEF, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    run_txn(32'h0000A55A, 1, 0, 1, 0, 8'hA5, 8'h11, 5);
    run_txn(32'h12345678, 1, 1, 0, 0, 8'h3C, 8'hC3, 5);
    run_txn(32'hCAFEF00D, 1, 0, 0, 1, 8'h5A, 8'h96, 7);

    // reset during the second command byte
    exp_tx.push_back(8'h89);
    @(posedge clk); #1;
    cmd = 32'h89ABCDEF; snd_cmd = 1'b1;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    repeat (FRAME + 40) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_tx", TX, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flags", {cmd_snt, resp_rdy, timeout}, 3'b000);
    chk("mid_rst_resp", resp, 0);
    chk("mid_rst_txq", exp_tx.size(), 0);
    rst = 1'b0;
    last_resp = '0;
    repeat (3) @(posedge clk);
    run_txn(32'h76543210, 1, 0, 0, 0, 8'h42, 8'h24, 3);

    for (int t = 0; t < 25; t++)
      run_txn($urandom, 1, 0, 0, 0, 8'($urandom), 8'($urandom),
              $urandom_range(1, 20));

    repeat (50) @(posedge clk);
    chk("drain_tx", exp_tx.size(), 0);
    chk("drain_out", exp_out.size(), 0);
    chk("drain_rep", rep_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
